// File: rtl/pixel_job_queue.sv
// Show-ahead circular job queue between the pixel mapper and the engine distributor.
// Define PIXEL_QUEUE_ERR_FLAGS_EN to add the sticky overflow_err/underflow_err outputs.
module pixel_job_queue #(
    parameter int PIXEL_DATA_WIDTH  = 10,
    parameter int ENGINE_DATA_WIDTH = 25,
    parameter int DEPTH             = 16,
    parameter int FULL_SLACK        = 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                push,
    input  logic signed [ENGINE_DATA_WIDTH-1:0] real_x,
    input  logic signed [ENGINE_DATA_WIDTH-1:0] imag_y,
    input  logic        [PIXEL_DATA_WIDTH-1:0]  pixel_x_in,
    input  logic        [PIXEL_DATA_WIDTH-1:0]  pixel_y_in,
    output logic                                full_queue,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic signed [ENGINE_DATA_WIDTH-1:0] out_real,
    output logic signed [ENGINE_DATA_WIDTH-1:0] out_imag,
    output logic        [PIXEL_DATA_WIDTH-1:0]  out_pixel_x,
    output logic        [PIXEL_DATA_WIDTH-1:0]  out_pixel_y,
    output logic        [$clog2(DEPTH):0]       count
`ifdef PIXEL_QUEUE_ERR_FLAGS_EN
    ,
    output logic                                overflow_err,
    output logic                                underflow_err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int JW = 2 * ENGINE_DATA_WIDTH + 2 * PIXEL_DATA_WIDTH;
    localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
    localparam logic [CW-1:0] FULL_THRESH = CW'(DEPTH - FULL_SLACK);

    logic [JW-1:0] mem [DEPTH];
    logic [AW-1:0] wrPtr_q;
    logic [AW-1:0] rdPtr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          full_q;
    logic          doPush;
    logic          doPop;

    // A full queue still accepts a push when the head leaves in the same cycle.
    always_comb begin
        doPop   = (count_q != '0) && out_ready;
        doPush  = push && ((count_q < DEPTH_C) || doPop);
        count_d = count_q;
        case ({doPush, doPop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
            if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d >= FULL_THRESH);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr_q] <= {real_x, imag_y, pixel_x_in, pixel_y_in};
    end

    assign {out_real, out_imag, out_pixel_x, out_pixel_y} = mem[rdPtr_q];
    assign out_valid  = (count_q != '0);
    assign full_queue = full_q;
    assign count      = count_q;

`ifdef PIXEL_QUEUE_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    // Sticky until reset so software can inspect them after the fact.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push && !doPush)               overflow_q  <= 1'b1;
            if (out_ready && (count_q == '0))  underflow_q <= 1'b1;
        end
    end

    assign overflow_err  = overflow_q;
    assign underflow_err = underflow_q;
`endif

endmodule

// File: tb/tb_pixel_job_queue.sv
// Directed scoreboard bench for pixel_job_queue (default parameters).
module tb_pixel_job_queue;

    localparam int PW    = 10;
    localparam int EW    = 25;
    localparam int DEPTH = 16;
    localparam int SLACK = 1;

    typedef struct packed {
        logic [EW-1:0] re;
        logic [EW-1:0] im;
        logic [PW-1:0] px;
        logic [PW-1:0] py;
    } job_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 push;
    logic signed [EW-1:0] real_x;
    logic signed [EW-1:0] imag_y;
    logic        [PW-1:0] pixel_x_in;
    logic        [PW-1:0] pixel_y_in;
    logic                 full_queue;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [EW-1:0] out_real;
    logic signed [EW-1:0] out_imag;
    logic        [PW-1:0] out_pixel_x;
    logic        [PW-1:0] out_pixel_y;
    logic        [$clog2(DEPTH):0] count;
`ifdef PIXEL_QUEUE_ERR_FLAGS_EN
    logic overflow_err;
    logic underflow_err;
    logic expOvf = 1'b0;
    logic expUnf = 1'b0;
`endif

    job_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic lastAccepted;

    pixel_job_queue #(
        .PIXEL_DATA_WIDTH (PW),
        .ENGINE_DATA_WIDTH(EW),
        .DEPTH            (DEPTH),
        .FULL_SLACK       (SLACK)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .real_x     (real_x),
        .imag_y     (imag_y),
        .pixel_x_in (pixel_x_in),
        .pixel_y_in (pixel_y_in),
        .full_queue (full_queue),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_real   (out_real),
        .out_imag   (out_imag),
        .out_pixel_x(out_pixel_x),
        .out_pixel_y(out_pixel_y),
        .count      (count)
`ifdef PIXEL_QUEUE_ERR_FLAGS_EN
        ,
        .overflow_err (overflow_err),
        .underflow_err(underflow_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic job_t mkJob(input int k);
        job_t j;
        j.re = EW'(k);
        j.im = EW'(-3 * k);
        j.px = PW'(7 * k);
        j.py = PW'(k + 100);
        return j;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: head checked before the edge, occupancy and flags after it.
    task automatic applyStimulus(input logic p, input job_t j, input logic rdy);
        int   sizeBefore;
        logic popNow;
        logic pushNow;
        push       = p;
        real_x     = j.re;
        imag_y     = j.im;
        pixel_x_in = j.px;
        pixel_y_in = j.py;
        out_ready  = rdy;
        #1;
        sizeBefore = sb.size();
        popNow  = (sizeBefore != 0) && rdy;
        pushNow = p && ((sizeBefore < DEPTH) || popNow);
        checkOutput("out_valid", 128'(out_valid), 128'(sizeBefore != 0));
        if (popNow)
            checkOutput("head_job", 128'({out_real, out_imag, out_pixel_x, out_pixel_y}), 128'(sb[0]));
        @(posedge clk);
        #1;
        if (popNow) void'(sb.pop_front());
        if (pushNow) sb.push_back(j);
        lastAccepted = pushNow;
`ifdef PIXEL_QUEUE_ERR_FLAGS_EN
        if (p && !pushNow) expOvf = 1'b1;
        if (rdy && sizeBefore == 0) expUnf = 1'b1;
        checkOutput("overflow_err", 128'(overflow_err), 128'(expOvf));
        checkOutput("underflow_err", 128'(underflow_err), 128'(expUnf));
`endif
        checkOutput("count", 128'(count), 128'(sb.size()));
        checkOutput("full_queue", 128'(full_queue), 128'(sb.size() >= DEPTH - SLACK));
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        while (sb.size() != 0 && guard < 4 * DEPTH) begin
            applyStimulus(1'b0, mkJob(0), 1'b1);
            guard++;
        end
        checkOutput(tag, 128'(sb.size()), 128'(0));
    endtask

    initial begin
        int pushed;
        int guard;
        reset = 1'b1;
        push = 1'b0;
        out_ready = 1'b0;
        real_x = '0;
        imag_y = '0;
        pixel_x_in = '0;
        pixel_y_in = '0;
        #1;
        checkOutput("reset_count", 128'(count), 128'(0));
        checkOutput("reset_valid", 128'(out_valid), 128'(0));
        checkOutput("reset_full", 128'(full_queue), 128'(0));
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] three jobs in, three out in order");
        for (int k = 1; k <= 3; k++) applyStimulus(1'b1, mkJob(k), 1'b0);
        for (int k = 1; k <= 3; k++) applyStimulus(1'b0, mkJob(0), 1'b1);
        checkOutput("empty_after_three", 128'(count), 128'(0));

        $display("[TB] fill to capacity, 17th push dropped");
        for (int k = 0; k < DEPTH + 1; k++) applyStimulus(1'b1, mkJob(10 + k), 1'b0);
        checkOutput("saturated_count", 128'(count), 128'(DEPTH));

        $display("[TB] push and pop together while full");
        applyStimulus(1'b1, mkJob(50), 1'b1);
        checkOutput("full_pushpop_count", 128'(count), 128'(DEPTH));
        drain("drain_full");

        $display("[TB] 40 jobs with random out_ready across wrap-around");
        pushed = 0;
        guard = 0;
        while (pushed < 40 && guard < 400) begin
            applyStimulus(1'b1, mkJob(100 + pushed), 1'($urandom_range(0, 1)));
            if (lastAccepted) pushed++;
            guard++;
        end
        checkOutput("random_push_budget", 128'(pushed), 128'(40));
        drain("drain_random");

        $display("[TB] asynchronous reset with five jobs queued");
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, mkJob(200 + k), 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_rst_count", 128'(count), 128'(0));
        checkOutput("async_rst_valid", 128'(out_valid), 128'(0));
        checkOutput("async_rst_full", 128'(full_queue), 128'(0));
        sb.delete();
`ifdef PIXEL_QUEUE_ERR_FLAGS_EN
        expOvf = 1'b0;
        expUnf = 1'b0;
`endif
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b1, mkJob(77), 1'b0);
        applyStimulus(1'b0, mkJob(0), 1'b1);

        $display("[TB] out_ready on empty queue");
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, mkJob(0), 1'b1);
        checkOutput("empty_ready_count", 128'(count), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
